// File: rtl/bcd_convert_if.sv
// Request/result bundle between a binary producer and the BCD converter.
interface bcd_convert_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;

    modport master (output start, output bin, input busy, input done, input bcd);
    modport slave  (input start, input bin, output busy, output done, output bcd);
endinterface

// File: rtl/bcd_convert.sv
// Binary-to-BCD converter (double-dabble), one bit per clock; done pulses WIDTH cycles after start is taken.
// No backpressure: start is only accepted while idle and is dropped (not queued) while busy.
module bcd_convert #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    bcd_convert_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [BW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [BW-1:0]    acc_adj;

    // Per-digit add-3; digits 10..15 are left untouched and no carry crosses nibbles.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5 && acc_q[4*i +: 4] <= 4'd9)
                acc_adj[4*i +: 4] = 4'(acc_q[4*i +: 4] + 4'd3);
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sh_d    = bus.bin;
                    acc_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {acc_d, sh_d} = {acc_adj, sh_q} << 1;
                cnt_d         = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d   = acc_d;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.bcd  = bcd_q;
endmodule

// File: doc/bcd_convert.md
# bcd_convert

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It sits directly upstream of the calculator's per-digit display and decode logic. It takes the binary result of a sort or arithmetic operation and produces packed BCD digits. Each digit correction applies the same add-3 rule as the existing digit-adjust stage: a digit of 5..9 has 3 added to it.

## Interface
- WIDTH, 8, bit width of the binary input.
- DIGITS, 3, number of BCD output digits. The integrator must keep 10^DIGITS > 2^WIDTH − 1; the block does not check this.
- clk  in  1  system clock, rising-edge active.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  conversion request, sampled only in IDLE.
- bin  in  WIDTH  binary operand, captured on the edge that accepts start.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse; bcd is valid and updated in this cycle.
- bcd  out  4*DIGITS  packed result. Digit 0 (ones) is in bcd[3:0]; the most significant digit is in the top nibble.

## Operation
- Datapath registers:
  - sh: WIDTH-bit binary shift register.
  - acc: 4*DIGITS-bit BCD accumulator.
  - cnt: iteration counter, range 0..WIDTH.
  - bcd: output holding register.
- FSM states: IDLE, SHIFT.
- IDLE:
  - If start = 1: load sh ← bin, acc ← 0, cnt ← WIDTH; go to SHIFT.
  - Otherwise hold all state.
- SHIFT, each cycle:
  - For every digit of acc: if the digit is 5..9, add 3 (4-bit result, no carry between digits). Otherwise leave the digit unchanged.
  - Then shift {acc, sh} left by 1. The MSB of sh enters bit 0 of acc; the LSB of sh becomes 0.
  - Decrement cnt.
- On the SHIFT cycle where cnt goes 1 → 0:
  - Load bcd with the post-shift acc value.
  - Assert done.
  - Return to IDLE.
- bcd holds its value until the next completion. It is not cleared when a new conversion starts.
- start while busy = 1 is ignored and is not queued.
- Changes on bin after it is captured have no effect on the conversion in progress.
- Digit values 10..15 cannot occur with a legal DIGITS setting. If they do occur, they pass through uncorrected.

## Timing
- Reset (rst_n = 0, asynchronous):
  - State goes to IDLE.
  - busy = 0, done = 0, bcd = 0, acc = 0, sh = 0, cnt = 0.
- Reset asserted mid-conversion aborts the conversion immediately. No done pulse is issued, and bcd reads 0.
- Latency:
  - start is sampled at rising edge E.
  - busy = 1 from after E through edge E+WIDTH.
  - done = 1 for exactly one cycle, after edge E+WIDTH (8 cycles for the defaults).
- busy and done are registered outputs. busy falls on the same edge at which done rises.
- During the done cycle the FSM is in IDLE, so a start in that cycle is accepted.
- If start is held high continuously, a conversion begins every WIDTH+1 cycles (9 for the defaults).
- A rising edge on rst_n alone never starts a conversion; start must be sampled high.

## Test plan
- After reset, with no start: bcd = 0x000, busy = 0, done = 0 for 20 cycles.
- bin = 0 → bcd = 0x000, with done exactly 8 cycles after start is sampled. bin = 255 → 0x255. bin = 99 → 0x099. bin = 100 → 0x100. bin = 9 → 0x009.
- Sweep all bin values 0..255 → bcd equals the decimal digits of each value in every case. A scoreboard confirms the result updates only when done is high.
- Pulse start again at cycle 3 of a conversion, with bin changed to 17: the original conversion completes with its captured value, no second done follows, and busy stays high for exactly 8 cycles.
- Hold start high, with bin = 12 and then bin = 200 → results 0x012 then 0x200, with done pulses 9 cycles apart.
- Assert rst_n = 0 at cycle 4 of converting 255: busy, done and bcd go to 0 immediately. A subsequent conversion of 37 yields 0x037.
